// File: rtl/therm_stream_sched.sv
// therm_stream_sched
//   Round-robin scheduler that shares one one-hot -> thermometer converter
//   among R requesters. A granted value v (clamped to N) is decoded to
//   one-hot, converted to an N-bit thermometer word with v ones in the
//   LSBs, then emitted as an N-cycle unary stochastic bitstream.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid[R]          per-requester request
//   req_value[R*W]        per-requester value, slice i = [i*W +: W]
//   req_ready[R]          one-hot grant, only while idle
//   bs_out/bs_valid       stream bit and its valid
//   bs_ready              downstream accept
//   bs_tag                requester index owning the current stream
//   bs_last               marks the N-th bit of a stream

module onehot_to_therm #(
  parameter int N   = 8,
  parameter int DIR = 0
) (
  input  logic [N-1:0] oh_i,
  output logic [N-1:0] therm_o
);
  // DIR=0: every bit at or below the hot bit is set (ones fill the LSBs).
  for (genvar i = 0; i < N; i++) begin : g_bit
    if (DIR == 0) begin : g_lo
      assign therm_o[i] = |oh_i[N-1:i];
    end else begin : g_hi
      assign therm_o[i] = |oh_i[i:0];
    end
  end
endmodule

module therm_stream_sched #(
  parameter  int N          = 8,
  parameter  int R          = 4,
  parameter  int ONES_FIRST = 1,
  localparam int W          = $clog2(N + 1),
  localparam int TW         = (R > 1) ? $clog2(R) : 1,
  localparam int CW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_valid,
  input  logic [R*W-1:0]  req_value,
  output logic [R-1:0]    req_ready,
  output logic            bs_out,
  output logic            bs_valid,
  input  logic            bs_ready,
  output logic [TW-1:0]   bs_tag,
  output logic            bs_last
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t          state_q;
  logic [TW-1:0]   ptr_q;
  logic [TW-1:0]   tag_q;
  logic [W-1:0]    v_q;
  logic [N-1:0]    sh_q;
  logic [CW-1:0]   cnt_q;

  // Round-robin pick: first valid requester at or above ptr_q, wrapping.
  logic          gnt_vld;
  logic [TW-1:0] gnt_idx;
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < R; k++) begin
      j = int'(ptr_q) + k;
      if (j >= R) j = j - R;
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = TW'(j);
      end
    end
  end

  logic [W-1:0] sel_v, clamp_v;
  assign sel_v   = req_value[gnt_idx*W +: W];
  assign clamp_v = (sel_v > W'(N)) ? W'(N) : sel_v;

  // Grant only while idle and out of reset so reset presents all-zero outputs.
  logic [R-1:0] grant_oh;
  assign grant_oh  = {{(R-1){1'b0}}, 1'b1} << gnt_idx;
  assign req_ready = (state_q == S_IDLE && !rst && gnt_vld) ? grant_oh : '0;

  logic [N-1:0] oh, therm;
  assign oh = (v_q == '0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << (v_q - W'(1)));

  onehot_to_therm #(.N(N), .DIR(0)) u_conv (
    .oh_i    (oh),
    .therm_o (therm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      v_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            v_q     <= clamp_v;
            tag_q   <= gnt_idx;
            ptr_q   <= (gnt_idx == TW'(R - 1)) ? '0 : gnt_idx + TW'(1);
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          sh_q    <= therm;
          cnt_q   <= '0;
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (bs_ready) begin
            // Shift the consumed bit out toward the emitting end.
            sh_q <= (ONES_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
            if (cnt_q == CW'(N - 1)) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; they hold while bs_ready is low.
  logic streaming;
  assign streaming = (state_q == S_STREAM);
  assign bs_valid  = streaming;
  assign bs_out    = streaming && ((ONES_FIRST != 0) ? sh_q[0] : sh_q[N-1]);
  assign bs_tag    = streaming ? tag_q : '0;
  assign bs_last   = streaming && (cnt_q == CW'(N - 1));

endmodule
